// File: rtl/led_mmio_ctrl.sv
// Memory-mapped slave that holds the seven-segment display value, control and prescaler
// registers. Optional binary-to-BCD conversion is compiled in with LED_BIN2BCD_EN.
module led_mmio_ctrl #(
    parameter int                   DIV_WIDTH   = 16,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 16'd49999
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [3:0]  REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [3:0]  REQ_WSTRB,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        LED_EN,
    output logic [31:0] LED_DATA,
    output logic        FLUSH_CLK
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic [31:0]          r_rsp_rdata;
    logic                 r_led_en;
    logic [31:0]          r_led_data;
    logic                 r_flush;
    logic [31:0]          r_data;
    logic                 r_freeze;
    logic [DIV_WIDTH-1:0] r_prescale;
    logic [DIV_WIDTH-1:0] r_cnt;

    logic                 w_mode;
    logic                 w_accept;
    logic                 w_wr;
    logic [1:0]           w_sel;
    logic                 w_data_wr;
    logic                 w_ctrl_wr;
    logic                 w_pre_wr;
    logic [31:0]          w_data_merged;
    logic                 w_new_freeze;
    logic                 w_new_mode;
    logic [DIV_WIDTH-1:0] w_pre_merged;
    logic                 w_upd;
    logic [31:0]          w_upd_val;
    logic                 w_upd_mode;
    logic                 w_hex_upd;
    logic                 w_conv_start;
    logic                 w_conv_done;
    logic [31:0]          w_bcd_next;
    logic                 w_busy;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign REQ_READY = r_req_ready;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_RDATA = r_rsp_rdata;
    assign LED_EN    = r_led_en;
    assign LED_DATA  = r_led_data;
    assign FLUSH_CLK = r_flush;

    assign w_unused      = ^REQ_ADDR[1:0];
    assign w_accept      = REQ_VALID & r_req_ready;
    assign w_wr          = w_accept & REQ_WE;
    assign w_sel         = REQ_ADDR[3:2];
    assign w_data_wr     = w_wr & (w_sel == 2'd0) & (REQ_WSTRB != 4'd0);
    assign w_ctrl_wr     = w_wr & (w_sel == 2'd1);
    assign w_pre_wr      = w_wr & (w_sel == 2'd2) & (REQ_WSTRB != 4'd0);
    assign w_data_merged = byte_merge(r_data, REQ_WDATA, REQ_WSTRB);
    assign w_new_freeze  = REQ_WSTRB[0] ? REQ_WDATA[1] : r_freeze;
    assign w_busy        = (r_state == ST_CONV);

    // A display reload comes from an unfrozen DATA write or from releasing FREEZE.
    assign w_upd        = (w_data_wr & ~r_freeze) | (w_ctrl_wr & r_freeze & ~w_new_freeze);
    assign w_upd_val    = w_data_wr ? w_data_merged : r_data;
    assign w_upd_mode   = w_data_wr ? w_mode : w_new_mode;
    assign w_hex_upd    = w_upd & ~w_upd_mode;
    assign w_conv_start = w_upd & w_upd_mode;

`ifdef LED_BIN2BCD_EN
    logic        r_mode;
    logic [26:0] r_bin;
    logic [31:0] r_bcd;
    logic [4:0]  r_conv_cnt;
    logic [31:0] w_clamp;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
    function automatic logic [31:0] dd_step(input logic [31:0] bcd, input logic in_bit);
        logic [31:0] adj;
        for (int d = 0; d < 8; d++) begin
            adj[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? (bcd[4*d +: 4] + 4'd3) : bcd[4*d +: 4];
        end
        return {adj[30:0], in_bit};
    endfunction

    assign w_mode      = r_mode;
    assign w_new_mode  = REQ_WSTRB[0] ? REQ_WDATA[0] : r_mode;
    assign w_clamp     = (w_upd_val > 32'd99999999) ? 32'd99999999 : w_upd_val;
    assign w_bcd_next  = dd_step(r_bcd, r_bin[26]);
    assign w_conv_done = (r_state == ST_CONV) & (r_conv_cnt == 5'd26);

    // MODE register, only present when conversion is built in.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_mode <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_mode <= w_new_mode;
        end else begin
            r_mode <= r_mode;
        end
    end

    // Conversion datapath: load the clamped value, then one shift per CONV cycle.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_bin      <= 27'd0;
            r_bcd      <= 32'd0;
            r_conv_cnt <= 5'd0;
        end else if (w_conv_start) begin
            r_bin      <= 27'(w_clamp);
            r_bcd      <= 32'd0;
            r_conv_cnt <= 5'd0;
        end else if (r_state == ST_CONV) begin
            r_bin      <= {r_bin[25:0], 1'b0};
            r_bcd      <= w_bcd_next;
            r_conv_cnt <= r_conv_cnt + 5'd1;
        end else begin
            r_bin      <= r_bin;
            r_bcd      <= r_bcd;
            r_conv_cnt <= r_conv_cnt;
        end
    end
`else
    assign w_mode      = 1'b0;
    assign w_new_mode  = 1'b0;
    assign w_bcd_next  = 32'd0;
    assign w_conv_done = 1'b0;
`endif

    // Byte-strobed merge of the low DIV_WIDTH bits of a PRESCALE write.
    always_comb begin
        w_pre_merged = r_prescale;
        for (int i = 0; i < DIV_WIDTH; i++) begin
            if (REQ_WSTRB[i/8]) begin
                w_pre_merged[i] = REQ_WDATA[i];
            end else begin
                w_pre_merged[i] = r_prescale[i];
            end
        end
    end

    // Register read multiplexer.
    always_comb begin
        w_rdata = 32'd0;
        case (w_sel)
            2'd0:    w_rdata = r_data;
            2'd1:    w_rdata = {30'd0, r_freeze, w_mode};
            2'd2:    w_rdata = 32'(r_prescale);
            2'd3:    w_rdata = {31'd0, w_busy};
            default: w_rdata = 32'd0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_conv_start) begin
                    w_state_nxt = ST_CONV;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (w_conv_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CONV;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; READY is registered from the next state so it drops with CONV entry.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    // Response pulse carrying the pre-write register value.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rdata;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end
    end

    // DATA, FREEZE and PRESCALE registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_data     <= 32'd0;
            r_freeze   <= 1'b0;
            r_prescale <= DEFAULT_DIV;
        end else begin
            if (w_data_wr) begin
                r_data <= w_data_merged;
            end else begin
                r_data <= r_data;
            end
            if (w_ctrl_wr) begin
                r_freeze <= w_new_freeze;
            end else begin
                r_freeze <= r_freeze;
            end
            if (w_pre_wr) begin
                r_prescale <= w_pre_merged;
            end else begin
                r_prescale <= r_prescale;
            end
        end
    end

    // Display load strobe and value.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_led_en   <= 1'b0;
            r_led_data <= 32'd0;
        end else if (w_hex_upd) begin
            r_led_en   <= 1'b1;
            r_led_data <= w_upd_val;
        end else if (w_conv_done) begin
            r_led_en   <= 1'b1;
            r_led_data <= w_bcd_next;
        end else begin
            r_led_en   <= 1'b0;
            r_led_data <= r_led_data;
        end
    end

    // Free-running scan prescaler; a PRESCALE write restarts the count without toggling.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_cnt   <= '0;
            r_flush <= 1'b0;
        end else if (w_pre_wr) begin
            r_cnt   <= '0;
            r_flush <= r_flush;
        end else if (r_cnt == r_prescale) begin
            r_cnt   <= '0;
            r_flush <= ~r_flush;
        end else begin
            r_cnt   <= r_cnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
            r_flush <= r_flush;
        end
    end

endmodule

// File: tb/tb_led_mmio_ctrl.sv
// Self-checking bench for led_mmio_ctrl: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_led_mmio_ctrl;

`ifdef LED_BIN2BCD_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif
    localparam logic [15:0] DEF_DIV = 16'd49999;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_WE = 1'b0;
    logic [3:0]  REQ_ADDR = 4'd0;
    logic [31:0] REQ_WDATA = 32'd0;
    logic [3:0]  REQ_WSTRB = 4'd0;
    logic        REQ_READY, RSP_VALID, LED_EN, FLUSH_CLK;
    logic [31:0] RSP_RDATA, LED_DATA;

    int n_checks = 0;
    int n_errors = 0;

    led_mmio_ctrl dut (
        .CLK(CLK), .RESETN(RESETN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
        .LED_EN(LED_EN), .LED_DATA(LED_DATA), .FLUSH_CLK(FLUSH_CLK)
    );

    initial forever #5 CLK = ~CLK;

    // Behavioural model state
    logic [31:0] m_data = 32'd0;
    logic        m_freeze = 1'b0;
    logic        m_mode = 1'b0;
    logic [15:0] m_pre = DEF_DIV;
    int          m_cnt = 0;
    logic        m_flush = 1'b0;
    logic [31:0] m_led = 32'd0;
    int          m_conv_left = 0;
    logic [31:0] m_conv_res = 32'd0;
    logic        e_rsp_v = 1'b0;
    logic [31:0] e_rdata = 32'd0;
    logic        e_led_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input logic [31:0] val);
        logic [31:0] r;
        longint unsigned v;
        v = (val > 32'd99999999) ? 64'd99999999 : 64'(val);
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Model: reacts to the same edges as the DUT and predicts next-cycle outputs.
    initial begin
        logic        acc;
        logic [1:0]  sel;
        logic [31:0] w;
        logic        nm;
        forever begin
            @(posedge CLK or negedge RESETN);
            if (!RESETN) begin
                m_data = 32'd0; m_freeze = 1'b0; m_mode = 1'b0; m_pre = DEF_DIV;
                m_cnt = 0; m_flush = 1'b0; m_led = 32'd0; m_conv_left = 0;
                e_rsp_v = 1'b0; e_rdata = 32'd0; e_led_en = 1'b0;
            end else begin
                acc = REQ_VALID && (m_conv_left == 0);
                sel = REQ_ADDR[3:2];
                e_rsp_v = 1'b0; e_rdata = 32'd0; e_led_en = 1'b0;
                if (acc && REQ_WE && sel == 2'd2 && REQ_WSTRB != 4'd0) m_cnt = 0;
                else if (m_cnt == int'(m_pre)) begin m_cnt = 0; m_flush = !m_flush; end
                else m_cnt++;
                if (m_conv_left > 0) begin
                    m_conv_left--;
                    if (m_conv_left == 0) begin e_led_en = 1'b1; m_led = m_conv_res; end
                end
                if (acc) begin
                    e_rsp_v = 1'b1;
                    case (sel)
                        2'd0:    e_rdata = m_data;
                        2'd1:    e_rdata = {30'd0, m_freeze, m_mode};
                        2'd2:    e_rdata = {16'd0, m_pre};
                        default: e_rdata = 32'd0;
                    endcase
                    if (REQ_WE) begin
                        case (sel)
                            2'd0: if (REQ_WSTRB != 4'd0) begin
                                m_data = merge(m_data, REQ_WDATA, REQ_WSTRB);
                                if (!m_freeze) begin
                                    if (m_mode) begin m_conv_left = 27; m_conv_res = to_bcd(m_data); end
                                    else begin e_led_en = 1'b1; m_led = m_data; end
                                end
                            end
                            2'd1: begin
                                w = merge({30'd0, m_freeze, m_mode}, REQ_WDATA, REQ_WSTRB);
                                nm = FEAT ? w[0] : 1'b0;
                                if (m_freeze && !w[1]) begin
                                    if (nm) begin m_conv_left = 27; m_conv_res = to_bcd(m_data); end
                                    else begin e_led_en = 1'b1; m_led = m_data; end
                                end
                                m_freeze = w[1];
                                m_mode = nm;
                            end
                            2'd2: begin
                                w = merge({16'd0, m_pre}, REQ_WDATA, REQ_WSTRB);
                                m_pre = w[15:0];
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge CLK);
            chk("ready", {31'd0, REQ_READY}, {31'd0, m_conv_left == 0});
            chk("rsp_valid", {31'd0, RSP_VALID}, {31'd0, e_rsp_v});
            if (e_rsp_v) chk("rsp_rdata", RSP_RDATA, e_rdata);
            chk("led_en", {31'd0, LED_EN}, {31'd0, e_led_en});
            chk("led_data", LED_DATA, m_led);
            chk("flush_clk", {31'd0, FLUSH_CLK}, {31'd0, m_flush});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    // Issue one request from negedge+1; returns at negedge+1 of the response cycle.
    task automatic bus(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd);
        int n;
        n = 0;
        REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wd; REQ_WSTRB = st;
        rd = 32'd0;
        while (REQ_READY !== 1'b1 && n < 200) begin
            @(negedge CLK); #1; n++;
        end
        if (n >= 200) begin
            chk("ready_timeout", 32'(n), 32'd0);
            REQ_VALID = 1'b0;
        end else begin
            @(posedge CLK); #1;
            REQ_VALID = 1'b0; REQ_WE = 1'b0;
            @(negedge CLK);
            rd = RSP_RDATA;
            #1;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (REQ_READY !== 1'b1 && n < 100) begin
            n++; cyc(1);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        f0;
        int          n;
        logic [1:0]  sel;
        logic        we;
        logic [3:0]  st;
        logic [31:0] wd;

        #2 RESETN = 1'b0;
        cyc(3);
        chk("rst_ready", {31'd0, REQ_READY}, 32'd1);
        chk("rst_led_data", LED_DATA, 32'd0);
        chk("rst_flush", {31'd0, FLUSH_CLK}, 32'd0);
        chk("rst_rsp", {31'd0, RSP_VALID}, 32'd0);
        RESETN = 1'b1;
        cyc(2);

        bus(1'b1, 4'h0, 32'h12345678, 4'hF, rd);
        chk("t1_rsp", {31'd0, RSP_VALID}, 32'd1);
        chk("t1_en", {31'd0, LED_EN}, 32'd1);
        chk("t1_led", LED_DATA, 32'h12345678);
        chk("t1_model", m_led, 32'h12345678);
        cyc(1);
        chk("t1_en_once", {31'd0, LED_EN}, 32'd0);
        bus(1'b0, 4'h0, 32'd0, 4'h0, rd);
        chk("t1_read", rd, 32'h12345678);

        bus(1'b1, 4'h0, 32'hAABBCCDD, 4'h5, rd);
        chk("t2_merge", LED_DATA, 32'h12BB56DD);
        bus(1'b1, 4'h0, 32'hFFFFFFFF, 4'h0, rd);
        chk("t2_nostrb_ack", {31'd0, RSP_VALID}, 32'd1);
        chk("t2_nostrb_en", {31'd0, LED_EN}, 32'd0);
        chk("t2_nostrb_led", LED_DATA, 32'h12BB56DD);

        bus(1'b1, 4'h4, 32'h2, 4'h1, rd);
        bus(1'b1, 4'h0, 32'hCAFEF00D, 4'hF, rd);
        chk("t3_frz_en", {31'd0, LED_EN}, 32'd0);
        chk("t3_frz_led", LED_DATA, 32'h12BB56DD);
        bus(1'b0, 4'h0, 32'd0, 4'h0, rd);
        chk("t3_frz_data", rd, 32'hCAFEF00D);
        bus(1'b1, 4'h4, 32'h0, 4'h1, rd);
        chk("t3_unfrz_en", {31'd0, LED_EN}, 32'd1);
        chk("t3_unfrz_led", LED_DATA, 32'hCAFEF00D);

        bus(1'b1, 4'h4, 32'hFFFFFFFF, 4'h1, rd);
        bus(1'b0, 4'h4, 32'd0, 4'h0, rd);
        chk("ctrl_read", rd, FEAT ? 32'd3 : 32'd2);
        bus(1'b0, 4'hC, 32'd0, 4'h0, rd);
        chk("status_read", rd, 32'd0);
        bus(1'b1, 4'h4, 32'h0, 4'h1, rd);
        chk("ctrl_unfrz_led", LED_DATA, 32'hCAFEF00D);

        bus(1'b1, 4'h8, 32'hFFFF0003, 4'hF, rd);
        bus(1'b0, 4'h8, 32'd0, 4'h0, rd);
        chk("pre_read", rd, 32'd3);
        for (int k = 0; k < 3; k++) begin
            f0 = FLUSH_CLK; n = 0;
            while (FLUSH_CLK === f0 && n < 20) begin n++; cyc(1); end
            if (k > 0) chk("half_period", 32'(n), 32'd4);
        end
        cyc(2);
        f0 = FLUSH_CLK;
        bus(1'b1, 4'h8, 32'h0, 4'h3, rd);
        chk("pre0_hold", {31'd0, FLUSH_CLK}, {31'd0, f0});
        cyc(1);
        chk("pre0_tog1", {31'd0, FLUSH_CLK}, {31'd0, ~f0});
        cyc(1);
        chk("pre0_tog2", {31'd0, FLUSH_CLK}, {31'd0, f0});

`ifdef LED_BIN2BCD_EN
        bus(1'b1, 4'h4, 32'h1, 4'h1, rd);
        bus(1'b1, 4'h0, 32'd12345678, 4'hF, rd);
        wait_ready(n);
        chk("conv_busy_cycles", 32'(n), 32'd27);
        chk("conv_en", {31'd0, LED_EN}, 32'd1);
        chk("conv_led", LED_DATA, 32'h12345678);
        chk("conv_model", m_led, 32'h12345678);
        bus(1'b1, 4'h0, 32'hFFFFFFFF, 4'hF, rd);
        wait_ready(n);
        chk("clamp_led", LED_DATA, 32'h99999999);
        bus(1'b1, 4'h0, 32'd555, 4'hF, rd);
        cyc(9);
        RESETN = 1'b0;
        #1;
        chk("abort_ready", {31'd0, REQ_READY}, 32'd1);
        chk("abort_en", {31'd0, LED_EN}, 32'd0);
        chk("abort_led", LED_DATA, 32'd0);
        cyc(2);
        RESETN = 1'b1;
        cyc(40);
        chk("abort_ready_after", {31'd0, REQ_READY}, 32'd1);
`endif

        bus(1'b1, 4'h8, 32'h2, 4'h1, rd);
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 2));
            sel = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            st = 4'($urandom);
            wd = $urandom;
            if (sel == 2'd2) begin
                wd = {wd[31:16], 13'd0, wd[2:0]};
                if (st == 4'd0) st = 4'd1;
            end
            if (sel == 2'd1) wd = {wd[31:2], 2'($urandom_range(0, 3))};
            bus(we, {sel, 2'($urandom)}, wd, st, rd);
        end
        cyc(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
